// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM bridge (sram_ctrl).
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int unsigned SRAM_AW           = 18;
  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned WORD_IDX_W        = SRAM_AW - 1;
  localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/sram_ctrl_wait_counter.sv
// Wait-state counter: counts enabled cycles, tc flags the last cycle of LIMIT.
module wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/sram_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM half accesses.
// Optional macro ALIGN_CHECK_EN adds the err port and misaligned-request bypass.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_STATES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
`ifdef ALIGN_CHECK_EN
  ,
  output logic               err
`endif
);

  state_t                state, state_next;
  logic                  op_write;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic                  req;
  logic                  tc;
  logic                  cnt_clear;
  logic                  cnt_en;
  logic [WORD_IDX_W-1:0] word_index;
  logic                  bad_align;

  assign req        = mem_r_en | mem_w_en;
  assign word_index = WORD_IDX_W'((addr_q - BASE_ADDR) >> 2);

`ifdef ALIGN_CHECK_EN
  logic misaligned_q;
  assign bad_align = (address[1:0] != 2'b00);
  assign err       = (state == DONE) && misaligned_q;
`else
  assign bad_align = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
`ifdef ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        op_write <= mem_w_en;
        addr_q   <= address;
        wdata_q  <= wdata;
`ifdef ALIGN_CHECK_EN
        misaligned_q <= bad_align;
`endif
      end
      // Each half is sampled on the final wait-state cycle of its phase.
      if (!op_write && tc) begin
        if (state == LOW)  rdata[15:0]  <= sram_rdata;
        if (state == HIGH) rdata[31:16] <= sram_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    unique case (state)
      IDLE: begin
        ready = !req;
        if (req) state_next = bad_align ? DONE : LOW;
      end
      LOW: begin
        sram_addr  = {word_index, 1'b0};
        sram_we_n  = !op_write;
        sram_oe_n  = op_write;
        sram_wdata = op_write ? wdata_q[15:0] : '0;
        if (tc) state_next = HIGH;
      end
      HIGH: begin
        sram_addr  = {word_index, 1'b1};
        sram_we_n  = !op_write;
        sram_oe_n  = op_write;
        sram_wdata = op_write ? wdata_q[31:16] : '0;
        if (tc) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clearing on any state change restarts the count at entry to LOW and HIGH.
  assign cnt_clear = (state_next != state);
  assign cnt_en    = (state == LOW) || (state == HIGH);

  wait_counter #(
    .LIMIT(WAIT_STATES)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .enable(cnt_en),
    .tc    (tc)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: stimulus queues expected strobes/completions,
// a negedge monitor pops and compares them.
module tb_sram_ctrl;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;
  logic        sram_oe_n;
`ifdef ALIGN_CHECK_EN
  logic        err;
`endif

  sram_ctrl #(
    .BASE_ADDR  (32'd1024),
    .WAIT_STATES(WS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n)
`ifdef ALIGN_CHECK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  // SRAM behavioural model
  logic [15:0] mem [0:15];
  assign sram_rdata = mem[sram_addr[3:0]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (!sram_we_n) begin
      mem[sram_addr[3:0]] <= sram_wdata;
    end
  end

  typedef struct {
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        we_n;
    logic        oe_n;
  } strobe_t;

  typedef struct {
    int          low;
    bit          chk_rd;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  strobe_t strobe_q[$];
  done_t   done_q[$];
  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 1'b0;
  int      low_cnt = 0;
  strobe_t ms;
  done_t   md;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Queue the strobe cycles and completion expected from one access.
  task automatic expect_access(input bit wr, input logic [17:0] sa0, input logic [31:0] data,
                               input int nstrobes, input int low, input bit chk_rd,
                               input logic [31:0] rd_exp, input logic err_exp);
    strobe_t s;
    done_t   d;
    for (int i = 0; i < nstrobes; i++) begin
      s.addr  = (i < WS) ? sa0 : sa0 + 18'd1;
      s.wdata = wr ? ((i < WS) ? data[15:0] : data[31:16]) : 16'h0000;
      s.we_n  = !wr;
      s.oe_n  = wr;
      strobe_q.push_back(s);
    end
    d.low    = low;
    d.chk_rd = chk_rd;
    d.rdata  = rd_exp;
    d.err    = err_exp;
    done_q.push_back(d);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  // Issue one request, then scramble inputs to prove the latched copies are used.
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mem_w_en = w;
    mem_r_en = r;
    address  = a;
    wdata    = d;
    @(posedge clk); #1;
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
    address  = a ^ 32'h0000_0FF0;
    wdata    = ~d;
    wait_ready();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!sram_we_n || !sram_oe_n) begin
        if (strobe_q.size() == 0) begin
          check32("unexpected_strobe", {14'd0, sram_addr}, 32'hFFFF_FFFF);
        end else begin
          ms = strobe_q.pop_front();
          check32("sram_addr", {14'd0, sram_addr}, {14'd0, ms.addr});
          check32("sram_we_n", {31'd0, sram_we_n}, {31'd0, ms.we_n});
          check32("sram_oe_n", {31'd0, sram_oe_n}, {31'd0, ms.oe_n});
          if (!ms.we_n) check32("sram_wdata", {16'd0, sram_wdata}, {16'd0, ms.wdata});
        end
      end else begin
        check32("idle_wdata", {16'd0, sram_wdata}, 32'd0);
      end
      if (!ready) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        if (done_q.size() == 0) begin
          check32("unexpected_done", low_cnt, 32'hFFFF_FFFF);
        end else begin
          md = done_q.pop_front();
          check32("ready_low_cycles", low_cnt, md.low);
          if (md.chk_rd) check32("rdata", rdata, md.rdata);
`ifdef ALIGN_CHECK_EN
          check32("err", {31'd0, err}, {31'd0, md.err});
`endif
        end
        low_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address  = '0;
    wdata    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check32("rst_ready", {31'd0, ready}, 32'd1);
    check32("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check32("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check32("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    mon_en = 1'b1;

    // Write then read back word 0
    expect_access(1'b1, 18'd0, 32'hDEADBEEF, 2 * WS, 2 * WS + 1, 1'b0, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    expect_access(1'b0, 18'd0, 32'd0, 2 * WS, 2 * WS + 1, 1'b1, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b1, 32'd1024, 32'h0);

    // Back-to-back write/read at 1028 (half-words 2/3)
    expect_access(1'b1, 18'd2, 32'h11112222, 2 * WS, 2 * WS + 1, 1'b0, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'd1028, 32'h11112222);
    expect_access(1'b0, 18'd2, 32'd0, 2 * WS, 2 * WS + 1, 1'b1, 32'h11112222, 1'b0);
    access(1'b0, 1'b1, 32'd1028, 32'h0);

    // Simultaneous read+write request is a write; rdata must be left alone
    expect_access(1'b1, 18'd4, 32'hCAFEF00D, 2 * WS, 2 * WS + 1, 1'b0, 32'd0, 1'b0);
    access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    check32("rdata_hold", rdata, 32'h11112222);
    expect_access(1'b0, 18'd4, 32'd0, 2 * WS, 2 * WS + 1, 1'b1, 32'hCAFEF00D, 1'b0);
    access(1'b0, 1'b1, 32'd1032, 32'h0);

    // Reset on the 2nd HIGH cycle of a write to 1036
    expect_access(1'b1, 18'd6, 32'h55556666, WS + 2, WS + 3, 1'b0, 32'd0, 1'b0);
    @(posedge clk); #1;
    mem_w_en = 1'b1;
    address  = 32'd1036;
    wdata    = 32'h55556666;
    @(posedge clk); #1;
    mem_w_en = 1'b0;
    repeat (WS + 1) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check32("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check32("abort_ready", {31'd0, ready}, 32'd1);
    check32("abort_sram_addr", {14'd0, sram_addr}, 32'd0);
    check32("abort_rdata", rdata, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    // Reset also clears the model SRAM, so the aborted halves read back as zero
    expect_access(1'b0, 18'd6, 32'd0, 2 * WS, 2 * WS + 1, 1'b1, 32'h0000_0000, 1'b0);
    access(1'b0, 1'b1, 32'd1036, 32'h0);

    expect_access(1'b1, 18'd2, 32'hA5A5_5A5A, 2 * WS, 2 * WS + 1, 1'b0, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'd1028, 32'hA5A5_5A5A);
`ifdef ALIGN_CHECK_EN
    // Misaligned read: no strobes, err with ready one cycle after the request
    expect_access(1'b0, 18'd0, 32'd0, 0, 1, 1'b0, 32'd0, 1'b1);
    access(1'b0, 1'b1, 32'd1025, 32'h0);
`else
    // Low address bits ignored: 1029 maps to half-words 2/3
    expect_access(1'b0, 18'd2, 32'd0, 2 * WS, 2 * WS + 1, 1'b1, 32'hA5A5_5A5A, 1'b0);
    access(1'b0, 1'b1, 32'd1029, 32'h0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check32("strobe_q_empty", strobe_q.size(), 32'd0);
    check32("done_q_empty", done_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
